tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 178 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Step-sequenced tone generator: 16-step note pattern, phase accumulator, selectable
// waveform and attack/decay envelope, producing an offset-binary sample per sample tick.
module tone_sequencer #(
  parameter int unsigned    SAMPLE_DIV   = 1024,
  parameter int unsigned    STEP_SAMPLES = 4096,
  parameter int unsigned    DECAY_DIV    = 16,
  parameter logic [127:0]   PATTERN      = 128'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [1:0]  wave_sel,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic [3:0]  step_index,
  output logic        note_active
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned SW = $clog2(STEP_SAMPLES);
  localparam int unsigned DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_SAMPLES - 1);
  localparam logic [DW-1:0] DEC_MAX  = DW'(DECAY_DIV - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, DECAY, REST} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [DW-1:0] dec_cnt_q, dec_cnt_d;
  logic [15:0]   phase_q, phase_d;
  logic [7:0]    env_q, env_d;
  logic [1:0]    wave_q, wave_d;
  logic [3:0]    step_q, step_d;
  logic [15:0]   sample_q, sample_d;
  logic          strobe_q, strobe_d;

  logic          tick, step_end;
  logic [3:0]    step_nxt;
  logic [7:0]    code_cur, code_nxt;
  logic [15:0]   inc;
  logic [8:0]    env_sum;
  logic [7:0]    env_att;
  logic [7:0]    tri_t, w;
  logic [15:0]   prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      dec_cnt_q  <= '0;
      phase_q    <= '0;
      env_q      <= '0;
      wave_q     <= '0;
      step_q     <= '0;
      sample_q   <= 16'h8000;
      strobe_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      phase_q    <= phase_d;
      env_q      <= env_d;
      wave_q     <= wave_d;
      step_q     <= step_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    step_nxt = step_q + 4'd1;
    code_cur = PATTERN[{step_q, 3'b000} +: 8];
    code_nxt = PATTERN[{step_nxt, 3'b000} +: 8];
    inc      = {4'b0000, code_cur, 4'b0000};
    tick     = run && (state_q != IDLE) && (tick_cnt_q == TICK_MAX);
    step_end = tick && (step_cnt_q == STEP_MAX);
    env_sum  = {1'b0, env_q} + 9'd16;
    env_att  = env_sum[8] ? 8'hFF : env_sum[7:0];
    tri_t    = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
    unique case (wave_q)
      2'd1:    w = phase_q[15:8] ^ 8'h80;
      2'd2:    w = tri_t ^ 8'h80;
      default: w = phase_q[15] ? 8'h80 : 8'h7F;
    endcase
    // Low 16 bits of an unsigned product of sign-extended operands equal the signed product.
    prod = {{8{w[7]}}, w} * {8'h00, env_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = (PATTERN[7:0] == 8'h00) ? REST : ATTACK;
      end
      ATTACK, DECAY, REST: begin
        if (!run) begin
          state_d = IDLE;
        end else if (step_end) begin
          state_d = (code_nxt == 8'h00) ? REST : ATTACK;
        end else if (tick && state_q == ATTACK && env_att == 8'hFF) begin
          state_d = DECAY;
        end
      end
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_cnt_d = step_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    phase_d    = phase_q;
    env_d      = env_q;
    wave_d     = wave_q;
    step_d     = step_q;
    sample_d   = sample_q;
    strobe_d   = 1'b0;
    if (state_q == IDLE || !run) begin
      tick_cnt_d = '0;
      step_cnt_d = '0;
      dec_cnt_d  = '0;
      phase_d    = '0;
      env_d      = '0;
      step_d     = '0;
      sample_d   = 16'h8000;
      if (run) wave_d = wave_sel;
    end else begin
      tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        sample_d = prod ^ 16'h8000;
        strobe_d = 1'b1;
        if (step_end) begin
          step_d     = step_nxt;
          step_cnt_d = '0;
          dec_cnt_d  = '0;
          phase_d    = '0;
          env_d      = '0;
          wave_d     = wave_sel;
        end else begin
          step_cnt_d = step_cnt_q + SW'(1);
          unique case (state_q)
            ATTACK: begin
              phase_d = phase_q + inc;
              env_d   = env_att;
            end
            DECAY: begin
              phase_d = phase_q + inc;
              if (dec_cnt_q == DEC_MAX) begin
                dec_cnt_d = '0;
                env_d     = (env_q == 8'h00) ? 8'h00 : env_q - 8'd1;
              end else begin
                dec_cnt_d = dec_cnt_q + DW'(1);
              end
            end
            default: env_d = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    sample_out    = sample_q;
    sample_strobe = strobe_q;
    step_index    = step_q;
    note_active   = (state_q == ATTACK) || (state_q == DECAY);
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a tick-level model queues expected samples,
// per-DUT monitors pop and compare on every strobe; a hand-computed table spot-checks values.
module tb_tone_sequencer;

  localparam logic [127:0] PAT_A = {{12{8'h08}}, 8'h40, 8'h00, 8'hFF, 8'h10};
  localparam logic [127:0] PAT_B = {8'h2F, 8'h2E, 8'h2D, 8'h2C, 8'h2B, 8'h2A, 8'h29, 8'h28,
                                    8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h00, 8'h20};

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  st;
    logic        na;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_a = 1'b0, run_b = 1'b0;
  logic [1:0]  ws_a = 2'd0, ws_b = 2'd1;
  logic [15:0] sample_a, sample_b;
  logic        strobe_a, strobe_b;
  logic [3:0]  step_a, step_b;
  logic        na_a, na_b;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   idx_a = 0, idx_b = 0;
  int   tot_a = 0, tot_b = 0;
  bit   hand_on_a = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  tone_sequencer #(.SAMPLE_DIV(4), .STEP_SAMPLES(64), .DECAY_DIV(1), .PATTERN(PAT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .wave_sel(ws_a),
    .sample_out(sample_a), .sample_strobe(strobe_a), .step_index(step_a), .note_active(na_a)
  );

  tone_sequencer #(.SAMPLE_DIV(4), .STEP_SAMPLES(8), .DECAY_DIV(2), .PATTERN(PAT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .wave_sel(ws_b),
    .sample_out(sample_b), .sample_strobe(strobe_b), .step_index(step_b), .note_active(na_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit to_b, input int nticks, input int ssamp, input int ddiv,
                       input logic [127:0] pat, input logic [31:0] wvs);
    int s, k, ph, env, dc, st, code, wave, p8, t, w, smp;
    exp_t e;
    s = 0; k = 0; ph = 0; env = 0; dc = 0;
    st = (pat[7:0] != 8'h00) ? 1 : 3;
    for (int g = 0; g < nticks; g++) begin
      code = int'(pat[(s % 16) * 8 +: 8]);
      wave = int'(wvs[(s % 16) * 2 +: 2]);
      p8 = (ph >> 8) & 255;
      t  = (ph >> 7) & 255;
      if (ph >= 32768) t = 255 - t;
      case (wave)
        1:       w = p8 - 128;
        2:       w = t - 128;
        default: w = (ph >= 32768) ? -128 : 127;
      endcase
      smp = (w * env + 32768) & 65535;
      if (k == ssamp - 1) begin
        s++; k = 0; ph = 0; env = 0; dc = 0;
        st = (pat[(s % 16) * 8 +: 8] != 8'h00) ? 1 : 3;
      end else begin
        k++;
        if (st == 1) begin
          ph = (ph + code * 16) & 65535;
          env = (env + 16 > 255) ? 255 : env + 16;
          if (env == 255) st = 2;
        end else if (st == 2) begin
          ph = (ph + code * 16) & 65535;
          dc++;
          if (dc == ddiv) begin
            dc = 0;
            if (env > 0) env--;
          end
        end
      end
      e.s  = smp[15:0];
      e.st = 4'(s % 16);
      e.na = (st == 1 || st == 2);
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  function automatic logic [16:0] hand_a(input int t);
    case (t)
      1:       return {1'b1, 16'h8000};
      2:       return {1'b1, 16'h87F0};
      16:      return {1'b1, 16'hF710};
      17:      return {1'b1, 16'hFE81};
      18:      return {1'b1, 16'hFE02};
      64:      return {1'b1, 16'hE730};
      65:      return {1'b1, 16'h8000};
      66:      return {1'b1, 16'h78F0};
      67:      return {1'b1, 16'h73E0};
      130:     return {1'b1, 16'h8000};
      194:     return {1'b1, 16'h7880};
      195:     return {1'b1, 16'h7200};
      default: return '0;
    endcase
  endfunction

  function automatic logic [21:0] hand_b(input int t);
    case (t)
      2:       return {1'b1, 1'b1, 4'd0, 16'h7820};
      8:       return {1'b1, 1'b0, 4'd1, 16'h4E20};
      12:      return {1'b1, 1'b0, 4'd1, 16'h8000};
      128:     return {1'b1, 1'b1, 4'd0, 16'h50C0};
      129:     return {1'b1, 1'b1, 4'd0, 16'h8000};
      130:     return {1'b1, 1'b1, 4'd0, 16'h7820};
      default: return '0;
    endcase
  endfunction

  initial begin
    int last;
    logic [16:0] h;
    exp_t e;
    last = -1;
    forever begin
      @(negedge clk);
      if (strobe_a) begin
        idx_a++;
        tot_a++;
        if (qa.size() == 0) begin
          chk("a_unexpected_strobe", 32'(idx_a), 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_sample", 32'(sample_a), 32'(e.s));
          chk("a_step", 32'(step_a), 32'(e.st));
          chk("a_note_active", 32'(na_a), 32'(e.na));
        end
        h = hand_a(idx_a);
        if (hand_on_a && h[16]) chk("a_hand_sample", 32'(sample_a), 32'(h[15:0]));
        if (last >= 0) chk("a_period", 32'(cyc - last), 32'd4);
        last = cyc;
      end
      if (!run_a || !rst_n) last = -1;
    end
  end

  initial begin
    int last;
    logic [21:0] h;
    exp_t e;
    last = -1;
    forever begin
      @(negedge clk);
      if (strobe_b) begin
        idx_b++;
        tot_b++;
        if (qb.size() == 0) begin
          chk("b_unexpected_strobe", 32'(idx_b), 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_sample", 32'(sample_b), 32'(e.s));
          chk("b_step", 32'(step_b), 32'(e.st));
          chk("b_note_active", 32'(na_b), 32'(e.na));
        end
        h = hand_b(idx_b);
        if (h[21]) begin
          chk("b_hand_sample", 32'(sample_b), 32'(h[15:0]));
          chk("b_hand_step", 32'(step_b), 32'(h[19:16]));
          chk("b_hand_active", 32'(na_b), 32'(h[20]));
        end
        if (last >= 0) chk("b_period", 32'(cyc - last), 32'd4);
        last = cyc;
      end
      if (!run_b || !rst_n) last = -1;
    end
  end

  task automatic wait_strobes(input bit is_b, input int n);
    int got, budget;
    got = 0;
    budget = n * 4 + 50;
    while (got < n && budget > 0) begin
      @(negedge clk);
      if (is_b ? strobe_b : strobe_a) got++;
      budget--;
    end
    if (got < n) chk(is_b ? "b_strobe_timeout" : "a_strobe_timeout", 32'(got), 32'(n));
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_sample"}, 32'(sample_a), 32'h8000);
    chk({tag, "_strobe"}, 32'(strobe_a), 32'd0);
    chk({tag, "_step"}, 32'(step_a), 32'd0);
    chk({tag, "_note_active"}, 32'(na_a), 32'd0);
  endtask

  initial begin
    int s0a, s0b;
    repeat (3) @(negedge clk);
    chk_idle_a("reset_a");
    chk("reset_b_sample", 32'(sample_b), 32'h8000);
    rst_n = 1'b1;

    s0a = tot_a; s0b = tot_b;
    repeat (1000) @(negedge clk);
    chk("idle_a_no_strobe", 32'(tot_a - s0a), 32'd0);
    chk("idle_b_no_strobe", 32'(tot_b - s0b), 32'd0);

    // step0 square, step1 saw, step2 saw (rest), step3 triangle
    model(1'b0, 222, 64, 1, PAT_A, 32'h0000_0094);
    hand_on_a = 1'b1;
    idx_a = 0;
    run_a = 1'b1;
    wait_strobes(1'b0, 20);
    ws_a = 2'd1;
    wait_strobes(1'b0, 120);
    ws_a = 2'd2;
    wait_strobes(1'b0, 82);
    run_a = 1'b0;
    @(negedge clk);
    chk_idle_a("run_drop_a");
    chk("a_run1_drained", 32'(qa.size()), 32'd0);

    s0a = tot_a;
    repeat (200) @(negedge clk);
    chk("idle2_a_no_strobe", 32'(tot_a - s0a), 32'd0);

    hand_on_a = 1'b0;
    model(1'b0, 5, 64, 1, PAT_A, 32'hAAAA_AAAA);
    idx_a = 0;
    run_a = 1'b1;
    wait_strobes(1'b0, 5);
    #2 rst_n = 1'b0;
    #1 chk_idle_a("async_rst_a");
    chk("a_run2_drained", 32'(qa.size()), 32'd0);
    @(negedge clk);
    run_a = 1'b0;
    rst_n = 1'b1;

    model(1'b1, 140, 8, 2, PAT_B, 32'h5555_5555);
    idx_b = 0;
    run_b = 1'b1;
    wait_strobes(1'b1, 140);
    run_b = 1'b0;
    @(negedge clk);
    chk("run_drop_b_sample", 32'(sample_b), 32'h8000);
    chk("run_drop_b_step", 32'(step_b), 32'd0);
    chk("run_drop_b_note_active", 32'(na_b), 32'd0);
    chk("b_drained", 32'(qb.size()), 32'd0);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
